fht_frame_loader: RTL and testbench
===================================

// Module: fht_frame_loader
// PURPOSE
//  Upstream feeder for fht_top. Accepts a stream of signed ADC samples with a valid/ready handshake.
//  Converts each sample to D_BIT fixed point and scatters it into fht_top's four RAM banks.
//  Writes go in bank-interleaved, bit-reversed order, then pulses start and waits for the transform to finish.
//  Replaces the bench-side write/reorder loop, so fht_top can run on a live ADC stream.
// PARAMETERS
//  ADC_WIDTH  16    width of the signed ADC sample
//  D_BIT      22    width of the fht_top data word
//  A_BIT      8     bank address width; BANK_SIZE = 2**A_BIT
//  SHIFT      4     left shift applied after sign extension (fractional bits); ADC_WIDTH+SHIFT <= D_BIT
//  CNT_W      16    width of the frame counter
// PORTS
//  iCLK         in   1          clock
//  iRESET       in   1          asynchronous reset, active high
//  iEN          in   1          enable; sampled only in IDLE
//  iADC_DATA    in   ADC_WIDTH  signed sample
//  iADC_VALID   in   1          sample valid
//  oADC_READY   out  1          loader accepts a sample this cycle
//  iFHT_RDY     in   1          fht_top oRDY
//  oWE          out  4          one-hot bank write enable to fht_top iWE
//  oDATA        out  D_BIT      write data, fanned out to iDATA_0..3
//  oADDR_WR     out  A_BIT      write address, fanned out to iADDR_WR_0..3
//  oSTART       out  1          one-cycle start pulse to fht_top iSTART
//  oFRAME_DONE  out  1          one-cycle pulse when fht_top completes a frame
//  oFRAME_CNT   out  CNT_W      completed-frame count, wraps modulo 2**CNT_W
//  oBUSY        out  1          high in any state other than IDLE
// BEHAVIOUR
//  Reset: every output 0, sample counter n=0, state=IDLE. Async assert, sync release.
//  Reset mid-frame discards the partial frame; nothing is written after reset asserts.
//  FSM states:
//   IDLE -> LOAD when iEN=1 and iFHT_RDY=1.
//   LOAD: oADC_READY=1; a transfer happens on iADC_VALID&oADC_READY; n increments per transfer.
//   LOAD -> START on the transfer with n=4*BANK_SIZE-1.
//   START: oADC_READY=0, oSTART=1 for exactly one cycle. The last write has already landed.
//   START -> WAIT_BUSY.
//   WAIT_BUSY -> WAIT_DONE when iFHT_RDY=0.
//   WAIT_DONE -> on iFHT_RDY=1: oFRAME_DONE=1 for one cycle, oFRAME_CNT++;
//     then LOAD if iEN=1, else IDLE.
//  Mapping for sample index n (0..4*BANK_SIZE-1):
//   bank = n[1:0]
//   oADDR_WR = bitrev_A_BIT(n[A_BIT+1:2])
//  Conversion: oDATA = sign_extend(iADC_DATA, D_BIT) <<< SHIFT. Exact by the parameter rule; no saturation.
//  Latency: a transfer in cycle k drives oWE/oDATA/oADDR_WR in cycle k+1 for exactly one cycle.
//   oWE=0 in all other cycles. oDATA and oADDR_WR hold their last value.
//  Gaps: iADC_VALID=0 in LOAD stalls without penalty. Back-to-back transfers give one write per cycle.
//  iEN deasserted mid-frame does not abort; it is honoured only at the WAIT_DONE exit.
//  iFHT_RDY glitching low in LOAD has no effect; it is sampled only in IDLE, WAIT_BUSY and WAIT_DONE.
//  oADC_READY=0 in IDLE, START, WAIT_BUSY and WAIT_DONE. Samples offered then are not consumed.
//  oFRAME_CNT wraps from 2**CNT_W-1 to 0.
//  Elaboration check: error if ADC_WIDTH+SHIFT > D_BIT.
// STRUCTURE
//  Shared package fht_loader_pkg:
//   enum state_t {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE}
//   function f_bit_rev(parameterised width)
//   this function is reused by the bench and by the output unloader
//  No sub-module: single FSM, sample counter, registered write port.
// TESTING (ADC_WIDTH=16, D_BIT=22, A_BIT=8, SHIFT=4)
//  1. Reset, then iEN=1 with iFHT_RDY=1:
//     oBUSY rises 1 cycle later; oADC_READY=1; all other outputs 0.
//  2. Address mapping:
//     n=0 -> oWE=0001, addr 0x00
//     n=5 -> oWE=0010, addr 0x80
//     n=6 -> oWE=0100, addr 0x80
//     n=1023 -> oWE=1000, addr 0xFF
//  3. Conversion:
//     iADC_DATA=16'h8000 -> oDATA=22'h380000
//     iADC_DATA=16'h7FFF -> oDATA=22'h07FFF0
//     iADC_DATA=16'h0001 -> oDATA=22'h000010
//  4. Full frame of 1024 samples with random valid gaps:
//     exactly 1024 writes, each bank/address written once, bank contents match the model;
//     oSTART is a single pulse one cycle after the final write.
//  5. fht_top or model drops iFHT_RDY 3 cycles after oSTART, raises it 500 cycles later:
//     oFRAME_DONE pulses once, oFRAME_CNT=1, oADC_READY stays 0 throughout the wait.
//  6. iRESET asserted after 300 samples:
//     outputs go to 0 asynchronously; after release a new frame starts at n=0, addr 0x00, oWE=0001.

Source files
------------

// File: rtl/fht_frame_loader_pkg.sv
// Shared types and helpers for the fht_top frame loader and its neighbours
// (output unloader, benches).
package fht_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    // Widest value f_bit_rev can handle; callers pass the live width.
    localparam int BR_MAX = 32;

    // Reverse the low w bits of v; bits above w come back zero.
    function automatic logic [BR_MAX-1:0] f_bit_rev(input logic [BR_MAX-1:0] v, input int w);
        logic [BR_MAX-1:0] r;
        r = {<<{v}};
        return r >> (BR_MAX - w);
    endfunction

endpackage

// File: rtl/fht_frame_loader_if.sv
// ADC stream, control and fht_top write port of the frame loader.
// master = loader side, slave = ADC/fht_top (or bench) side.
interface fht_frame_loader_if #(
    parameter int ADC_WIDTH = 16,
    parameter int D_BIT     = 22,
    parameter int A_BIT     = 8,
    parameter int CNT_W     = 16
);
    logic                 iEN;
    logic [ADC_WIDTH-1:0] iADC_DATA;
    logic                 iADC_VALID;
    logic                 oADC_READY;
    logic                 iFHT_RDY;
    logic [3:0]           oWE;
    logic [D_BIT-1:0]     oDATA;
    logic [A_BIT-1:0]     oADDR_WR;
    logic                 oSTART;
    logic                 oFRAME_DONE;
    logic [CNT_W-1:0]     oFRAME_CNT;
    logic                 oBUSY;

    modport master (
        input  iEN, iADC_DATA, iADC_VALID, iFHT_RDY,
        output oADC_READY, oWE, oDATA, oADDR_WR, oSTART, oFRAME_DONE, oFRAME_CNT, oBUSY
    );

    modport slave (
        output iEN, iADC_DATA, iADC_VALID, iFHT_RDY,
        input  oADC_READY, oWE, oDATA, oADDR_WR, oSTART, oFRAME_DONE, oFRAME_CNT, oBUSY
    );
endinterface

// File: rtl/fht_frame_loader.sv
// Streams one frame of ADC samples into fht_top's four banks in
// bank-interleaved, bit-reversed order, kicks the transform and waits for it.
module fht_frame_loader
    import fht_loader_pkg::*;
#(
    parameter int ADC_WIDTH = 16,
    parameter int D_BIT     = 22,
    parameter int A_BIT     = 8,
    parameter int SHIFT     = 4,
    parameter int CNT_W     = 16
) (
    input  logic             iCLK,
    input  logic             iRESET,
    fht_frame_loader_if.master bus
);
    localparam int N_W = A_BIT + 2;
    localparam logic [N_W-1:0] N_LAST = '1;

    // Conversion must be lossless: the shifted sample has to fit the data word.
    if (ADC_WIDTH + SHIFT > D_BIT) begin : g_width_chk
        $error("fht_frame_loader: ADC_WIDTH+SHIFT exceeds D_BIT");
    end

    // Reset asserts immediately, releases two clocks later on a clean edge.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst;
    assign rst_sync_d = {rst_sync_q[0], 1'b0};
    assign rst        = rst_sync_q[1];

    // Reset release synchroniser.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) rst_sync_q <= 2'b11;
        else        rst_sync_q <= rst_sync_d;
    end

    state_t             state_q, state_d;
    logic [N_W-1:0]     n_q, n_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               start_q, start_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         we_q, we_d;
    logic [D_BIT-1:0]   data_q, data_d;
    logic [A_BIT-1:0]   addr_q, addr_d;

    logic               xfer;
    logic signed [D_BIT-1:0] adc_ext;

    assign xfer    = ready_q & bus.iADC_VALID;
    assign adc_ext = D_BIT'(signed'(bus.iADC_DATA));

    // Next-state: write port fed by each transfer, frame sequencing FSM.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        we_d    = '0;
        data_d  = data_q;
        addr_d  = addr_q;

        // ready_q is only high in LOAD, so xfer implies LOAD.
        if (xfer) begin
            we_d   = 4'b0001 << n_q[1:0];
            data_d = adc_ext <<< SHIFT;
            addr_d = A_BIT'(f_bit_rev(BR_MAX'(n_q[N_W-1:2]), A_BIT));
            n_d    = n_q + 1'b1;
        end

        case (state_q)
            IDLE: if (bus.iEN && bus.iFHT_RDY) begin
                state_d = LOAD;
                n_d     = '0;
                ready_d = 1'b1;
                busy_d  = 1'b1;
            end
            LOAD: if (xfer && n_q == N_LAST) begin
                state_d = START;
                ready_d = 1'b0;
            end
            // Pulse start a cycle after the last write so the bank holds it.
            START: begin
                state_d = WAIT_BUSY;
                start_d = 1'b1;
            end
            WAIT_BUSY: if (!bus.iFHT_RDY) state_d = WAIT_DONE;
            WAIT_DONE: if (bus.iFHT_RDY) begin
                done_d = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                n_d    = '0;
                if (bus.iEN) begin
                    state_d = LOAD;
                    ready_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge iCLK or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            we_q    <= '0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.oADC_READY  = ready_q;
    assign bus.oBUSY       = busy_q;
    assign bus.oSTART      = start_q;
    assign bus.oFRAME_DONE = done_q;
    assign bus.oFRAME_CNT  = cnt_q;
    assign bus.oWE         = we_q;
    assign bus.oDATA       = data_q;
    assign bus.oADDR_WR    = addr_q;

endmodule

// File: tb/tb_fht_frame_loader.sv
// Directed bench for fht_frame_loader: reset, mapping, conversion,
// full frame, transform handshake and mid-frame reset.
module tb_fht_frame_loader;
    import fht_loader_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fht_frame_loader_if #(.ADC_WIDTH(16), .D_BIT(22), .A_BIT(8), .CNT_W(16)) bus ();

    fht_frame_loader #(
        .ADC_WIDTH(16), .D_BIT(22), .A_BIT(8), .SHIFT(4), .CNT_W(16)
    ) dut (
        .iCLK  (clk),
        .iRESET(rst),
        .bus   (bus.master)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sign-extend to 22 bits and append 4 fractional zeros.
    function automatic logic [21:0] conv(input logic [15:0] d);
        return {{2{d[15]}}, d, 4'h0};
    endfunction

    logic [15:0] samp [1024];
    logic [21:0] got_mem [4][256];
    bit          hit [4][256];

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Write-port monitor
    bit mon_en = 1'b0;
    bit in_wait = 1'b0;
    int wr_n = 0, dup = 0, bad_we = 0, last_wr_cyc = -1;
    int start_cnt = 0, start_cyc = -1, done_cnt = 0, rdy_hi = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.oWE != 4'b0000) begin
                if ($countones(bus.oWE) != 1) bad_we++;
                else begin
                    int b;
                    b = (bus.oWE[0]) ? 0 : (bus.oWE[1]) ? 1 : (bus.oWE[2]) ? 2 : 3;
                    if (hit[b][bus.oADDR_WR]) dup++;
                    hit[b][bus.oADDR_WR] = 1'b1;
                    got_mem[b][bus.oADDR_WR] = bus.oDATA;
                end
                case (wr_n)
                    0: begin
                        chk("map_n0_we", bus.oWE, 4'b0001);
                        chk("map_n0_addr", bus.oADDR_WR, 8'h00);
                        chk("conv_8000", bus.oDATA, 22'h380000);
                    end
                    1: chk("conv_7fff", bus.oDATA, 22'h07FFF0);
                    2: chk("conv_0001", bus.oDATA, 22'h000010);
                    5: begin
                        chk("map_n5_we", bus.oWE, 4'b0010);
                        chk("map_n5_addr", bus.oADDR_WR, 8'h80);
                    end
                    6: begin
                        chk("map_n6_we", bus.oWE, 4'b0100);
                        chk("map_n6_addr", bus.oADDR_WR, 8'h80);
                    end
                    1023: begin
                        chk("map_n1023_we", bus.oWE, 4'b1000);
                        chk("map_n1023_addr", bus.oADDR_WR, 8'hFF);
                    end
                    default: ;
                endcase
                last_wr_cyc = cyc;
                wr_n++;
            end
            if (bus.oSTART) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (bus.oFRAME_DONE) done_cnt++;
            if (in_wait && bus.oADC_READY) rdy_hi++;
        end
    end

    initial begin
        int n, budget, bad;
        bus.iEN = 1'b0;
        bus.iADC_DATA = '0;
        bus.iADC_VALID = 1'b0;
        bus.iFHT_RDY = 1'b0;
        samp[0] = 16'h8000;
        samp[1] = 16'h7FFF;
        samp[2] = 16'h0001;
        for (int i = 3; i < 1024; i++) samp[i] = 16'($urandom);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.oBUSY, 1'b0);
        chk("rst_ready", bus.oADC_READY, 1'b0);
        chk("rst_we", bus.oWE, 4'b0);
        chk("rst_start", bus.oSTART, 1'b0);
        chk("rst_cnt", bus.oFRAME_CNT, 16'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_busy", bus.oBUSY, 1'b0);

        // Enable: busy/ready one cycle later, everything else quiet
        bus.iEN = 1'b1;
        bus.iFHT_RDY = 1'b1;
        mon_en = 1'b1;
        chk("en_busy_pre", bus.oBUSY, 1'b0);
        @(negedge clk);
        chk("en_busy", bus.oBUSY, 1'b1);
        chk("en_ready", bus.oADC_READY, 1'b1);
        chk("en_we", bus.oWE, 4'b0);
        chk("en_start", bus.oSTART, 1'b0);
        chk("en_done", bus.oFRAME_DONE, 1'b0);
        chk("en_data", bus.oDATA, 22'h0);

        // Full frame with random valid gaps and iFHT_RDY glitches
        n = 0;
        budget = 0;
        while (n < 1024 && budget < 20000) begin
            bit v, xf;
            v = ($urandom_range(0, 3) != 0);
            bus.iADC_VALID = v;
            bus.iADC_DATA = samp[n];
            bus.iFHT_RDY = ((n % 200) != 100);
            xf = v && bus.oADC_READY;
            @(negedge clk);
            budget++;
            if (xf) n++;
        end
        chk("frame_xfers", n, 1024);
        bus.iADC_VALID = 1'b0;
        bus.iFHT_RDY = 1'b1;
        for (int i = 0; i < 20 && start_cnt == 0; i++) @(negedge clk);

        // Transform handshake; keep offering samples to prove none are taken
        in_wait = 1'b1;
        bus.iADC_VALID = 1'b1;
        repeat (2) @(negedge clk);
        bus.iFHT_RDY = 1'b0;
        repeat (500) @(negedge clk);
        bus.iEN = 1'b0;
        bus.iFHT_RDY = 1'b1;
        repeat (5) @(negedge clk);
        in_wait = 1'b0;
        bus.iADC_VALID = 1'b0;

        chk("frame_writes", wr_n, 1024);
        chk("frame_dup", dup, 0);
        chk("frame_onehot", bad_we, 0);
        chk("start_pulses", start_cnt, 1);
        chk("start_after_last_wr", start_cyc, last_wr_cyc + 1);
        chk("done_pulses", done_cnt, 1);
        chk("frame_cnt", bus.oFRAME_CNT, 16'd1);
        chk("wait_ready_low", rdy_hi, 0);
        chk("idle_after_done", bus.oBUSY, 1'b0);
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            int a;
            a = int'(f_bit_rev(32'(i >> 2), 8));
            if (!hit[i % 4][a] || got_mem[i % 4][a] !== conv(samp[i])) bad++;
        end
        chk("frame_mem", bad, 0);

        // Mid-frame reset after 300 samples
        mon_en = 1'b0;
        bus.iEN = 1'b1;
        bus.iADC_VALID = 1'b1;
        bus.iADC_DATA = 16'h1234;
        n = 0;
        budget = 0;
        while (n < 300 && budget < 2000) begin
            bit xf;
            xf = bus.oADC_READY;
            @(negedge clk);
            budget++;
            if (xf) n++;
        end
        chk("r6_xfers", n, 300);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("r6_busy", bus.oBUSY, 1'b0);
        chk("r6_ready", bus.oADC_READY, 1'b0);
        chk("r6_we", bus.oWE, 4'b0);
        chk("r6_data", bus.oDATA, 22'h0);
        chk("r6_addr", bus.oADDR_WR, 8'h0);
        chk("r6_cnt", bus.oFRAME_CNT, 16'h0);
        repeat (2) @(negedge clk);
        chk("r6_we_held", bus.oWE, 4'b0);
        rst = 1'b0;
        bus.iADC_VALID = 1'b0;
        for (int i = 0; i < 20 && !bus.oBUSY; i++) @(negedge clk);
        bus.iADC_VALID = 1'b1;
        bus.iADC_DATA = 16'h0010;
        @(negedge clk);
        for (int i = 0; i < 20 && bus.oWE == 4'b0; i++) @(negedge clk);
        chk("r6_first_we", bus.oWE, 4'b0001);
        chk("r6_first_addr", bus.oADDR_WR, 8'h00);
        chk("r6_first_data", bus.oDATA, 22'h000100);
        @(negedge clk);
        chk("r6_second_we", bus.oWE, 4'b0010);
        chk("r6_second_addr", bus.oADDR_WR, 8'h00);
        bus.iADC_VALID = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
